// File: rtl/usb_pkg.sv
// Shared types and constants for the USB receive path: rx state encoding,
// the decoded sync pattern, the bit-stuff run limit and the line levels.
package usb_pkg;

  typedef enum logic [1:0] {
    HUNT,
    DATA,
    DROP,
    EOP_WAIT
  } rx_state_t;

  // Sync as seen in the shift register: seven decoded 0s then a 1, newest at MSB.
  localparam logic [7:0] SYNC_DECODED = 8'h80;
  localparam logic [2:0] STUFF_LIMIT  = 3'd6;

  localparam logic LEVEL_J = 1'b1;
  localparam logic LEVEL_K = 1'b0;

endpackage

// File: rtl/usb_rx_decode_if.sv
// Bit stream from the line decoder into the receiver, and the byte/packet
// event stream back out. The line decoder side is the master.
interface usb_rx_decode_if;

  logic       in_bit;
  logic       in_valid;
  logic       in_eop;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       pkt_start;
  logic       pkt_end;
  logic       stuff_err;
  logic       align_err;

  modport master (
    output in_bit, in_valid, in_eop,
    input  byte_out, byte_valid, pkt_start, pkt_end, stuff_err, align_err
  );

  modport slave (
    input  in_bit, in_valid, in_eop,
    output byte_out, byte_valid, pkt_start, pkt_end, stuff_err, align_err
  );

endinterface

// File: rtl/usb_nrzi_dec.sv
// NRZI decoder: a bit decodes to 1 when the line level did not change since
// the previous valid bit. The reference level returns to J on every EOP cycle.
module usb_nrzi_dec
  import usb_pkg::*;
(
   input  logic clk,
   input  logic rst_L,
   input  logic in_bit,
   input  logic in_valid,
   input  logic in_eop,
   output logic dec_bit,
   output logic dec_valid
);

   logic prev_level;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, regardless of process order.
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         prev_level <= LEVEL_J;
      end else if (in_eop) begin
         prev_level <= LEVEL_J;
      end else if (in_valid) begin
         prev_level <= in_bit;
      end
   end

   // Decoded the same cycle the raw bit is presented; the receiver registers it.
   assign dec_bit   = (in_bit == prev_level);
   assign dec_valid = in_valid & ~in_eop;

endmodule

// File: rtl/usb_rx_decode.sv
// USB receive decoder: hunts for sync, removes stuffed bits, assembles bytes
// LSB first and flags packet start/end, stuffing and alignment errors.
module usb_rx_decode
  import usb_pkg::*;
(
   input  logic              clk,
   input  logic              rst_L,
   usb_rx_decode_if.slave    rx
);

   logic      dec_bit;
   logic      dec_valid;

   rx_state_t  state,      state_nxt;
   logic [7:0] sync_sr,    sync_sr_nxt;
   logic [7:0] byte_sr,    byte_sr_nxt;
   logic [2:0] bit_cnt,    bit_cnt_nxt;
   logic [2:0] ones_cnt,   ones_cnt_nxt;
   logic [7:0] byte_q,     byte_q_nxt;
   logic       byte_vld_q, byte_vld_nxt;
   logic       start_q,    start_nxt;
   logic       end_q,      end_nxt;
   logic       stuff_q,    stuff_nxt;
   logic       align_q,    align_nxt;

   logic [7:0] sync_shift;
   logic [7:0] data_shift;

   usb_nrzi_dec u_nrzi (
      .clk       (clk),
      .rst_L     (rst_L),
      .in_bit    (rx.in_bit),
      .in_valid  (rx.in_valid),
      .in_eop    (rx.in_eop),
      .dec_bit   (dec_bit),
      .dec_valid (dec_valid)
   );

   assign sync_shift = {dec_bit, sync_sr[7:1]};
   assign data_shift = {dec_bit, byte_sr[7:1]};

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         state      <= HUNT;
         sync_sr    <= '0;
         byte_sr    <= '0;
         bit_cnt    <= '0;
         ones_cnt   <= '0;
         byte_q     <= '0;
         byte_vld_q <= 1'b0;
         start_q    <= 1'b0;
         end_q      <= 1'b0;
         stuff_q    <= 1'b0;
         align_q    <= 1'b0;
      end else begin
         state      <= state_nxt;
         sync_sr    <= sync_sr_nxt;
         byte_sr    <= byte_sr_nxt;
         bit_cnt    <= bit_cnt_nxt;
         ones_cnt   <= ones_cnt_nxt;
         byte_q     <= byte_q_nxt;
         byte_vld_q <= byte_vld_nxt;
         start_q    <= start_nxt;
         end_q      <= end_nxt;
         stuff_q    <= stuff_nxt;
         align_q    <= align_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave a value unassigned and infer a latch.
      state_nxt    = state;
      sync_sr_nxt  = sync_sr;
      byte_sr_nxt  = byte_sr;
      bit_cnt_nxt  = bit_cnt;
      ones_cnt_nxt = ones_cnt;
      byte_q_nxt   = byte_q;
      byte_vld_nxt = 1'b0;
      start_nxt    = 1'b0;
      end_nxt      = 1'b0;
      stuff_nxt    = 1'b0;
      align_nxt    = 1'b0;

      case (state)
         HUNT: begin
            if (rx.in_eop) begin
               sync_sr_nxt = '0;
            end else if (dec_valid) begin
               sync_sr_nxt = sync_shift;
               if (sync_shift == SYNC_DECODED) begin
                  // The final 1 of sync already counts towards the stuffing run.
                  state_nxt    = DATA;
                  start_nxt    = 1'b1;
                  sync_sr_nxt  = '0;
                  ones_cnt_nxt = 3'd1;
                  bit_cnt_nxt  = '0;
               end
            end
         end

         DATA: begin
            if (rx.in_eop) begin
               end_nxt   = 1'b1;
               align_nxt = (bit_cnt != 3'd0);
               state_nxt = EOP_WAIT;
            end else if (dec_valid) begin
               if (ones_cnt == STUFF_LIMIT) begin
                  if (dec_bit) begin
                     stuff_nxt = 1'b1;
                     state_nxt = DROP;
                  end else begin
                     ones_cnt_nxt = '0;
                  end
               end else begin
                  ones_cnt_nxt = dec_bit ? ones_cnt + 3'd1 : 3'd0;
                  byte_sr_nxt  = data_shift;
                  bit_cnt_nxt  = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     byte_q_nxt   = data_shift;
                     byte_vld_nxt = 1'b1;
                  end
               end
            end
         end

         DROP: begin
            if (rx.in_eop) begin
               end_nxt   = 1'b1;
               state_nxt = EOP_WAIT;
            end
         end

         EOP_WAIT: begin
            if (!rx.in_eop) begin
               state_nxt    = HUNT;
               sync_sr_nxt  = '0;
               byte_sr_nxt  = '0;
               bit_cnt_nxt  = '0;
               ones_cnt_nxt = '0;
            end
         end

         default: begin
            state_nxt = HUNT;
         end
      endcase
   end

   assign rx.byte_out   = byte_q;
   assign rx.byte_valid = byte_vld_q;
   assign rx.pkt_start  = start_q;
   assign rx.pkt_end    = end_q;
   assign rx.stuff_err  = stuff_q;
   assign rx.align_err  = align_q;

endmodule

// File: tb/tb_usb_rx_decode.sv
// Bench for usb_rx_decode: a packet-level generator encodes sync, stuffing and
// NRZI, and records the outputs each step must produce; one process compares.
module tb_usb_rx_decode;

   typedef struct packed {
      logic [7:0] b;
      logic       ps;
      logic       bv;
      logic       pe;
      logic       ae;
      logic       se;
   } exp_t;

   localparam int MAXE = 40000;

   logic clk = 1'b0;
   logic rst_L = 1'b0;
   always #5 clk = ~clk;

   usb_rx_decode_if bus ();

   usb_rx_decode dut (
      .clk   (clk),
      .rst_L (rst_L),
      .rx    (bus)
   );

   exp_t exp_q [MAXE];
   int   edge_n = 0;
   int   n_checks = 0;
   int   n_err = 0;

   // Packet-level model state
   logic       level;
   int         run;
   int         nbits;
   bit         in_pkt;
   bit         dropped;
   bit         gaps_on;
   logic [7:0] acc;
   logic [7:0] last_byte;
   logic [7:0] raw_log;

   // Observed event counts, used by the directed literal checks
   int mon_ps, mon_bv, mon_pe, mon_se, mon_ae, mon_peae;
   logic [7:0] mon_byte;
   int s_ps, s_bv, s_pe, s_se, s_ae, s_peae;

   always @(posedge clk) edge_n <= edge_n + 1;

   exp_t e_now;
   always @(negedge clk) begin
      if (edge_n < MAXE) begin
         e_now = exp_q[edge_n];
         n_checks++;
         if (bus.byte_out !== e_now.b || bus.pkt_start !== e_now.ps ||
             bus.byte_valid !== e_now.bv || bus.pkt_end !== e_now.pe ||
             bus.align_err !== e_now.ae || bus.stuff_err !== e_now.se) begin
            n_err++;
            $display("FAIL outputs@cycle%0d: got byte=%h ps=%b bv=%b pe=%b ae=%b se=%b, expected byte=%h ps=%b bv=%b pe=%b ae=%b se=%b",
                     edge_n, bus.byte_out, bus.pkt_start, bus.byte_valid, bus.pkt_end,
                     bus.align_err, bus.stuff_err, e_now.b, e_now.ps, e_now.bv,
                     e_now.pe, e_now.ae, e_now.se);
         end
      end
      if (bus.pkt_start)  mon_ps++;
      if (bus.byte_valid) begin mon_bv++; mon_byte = bus.byte_out; end
      if (bus.pkt_end)    mon_pe++;
      if (bus.stuff_err)  mon_se++;
      if (bus.align_err)  mon_ae++;
      if (bus.pkt_end && bus.align_err) mon_peae++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // One clock of stimulus; the expectation is for the edge that samples it.
   task automatic step(input logic b, input logic v, input logic e, input logic ps,
                       input logic bv, input logic [7:0] byt, input logic pe,
                       input logic ae, input logic se);
      exp_t x;
      bus.in_bit   = b;
      bus.in_valid = v;
      bus.in_eop   = e;
      if (bv) last_byte = byt;
      x.b = last_byte; x.ps = ps; x.bv = bv; x.pe = pe; x.ae = ae; x.se = se;
      if (edge_n + 1 < MAXE) exp_q[edge_n + 1] = x;
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic maybe_gap();
      if (gaps_on && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
   endtask

   // Decoded 1 keeps the line level, decoded 0 toggles it.
   task automatic send_dec(input logic d, input logic ps, input logic bv,
                           input logic [7:0] byt, input logic se);
      level = d ? level : ~level;
      step(level, 1'b1, 1'b0, ps, bv, byt, 1'b0, 1'b0, se);
   endtask

   task automatic send_sync();
      for (int i = 0; i < 8; i++) begin
         send_dec(i == 7, i == 7, 1'b0, 8'h00, 1'b0);
         raw_log[i] = level;
         if (i < 7) maybe_gap();
      end
      in_pkt = 1; dropped = 0; run = 1; nbits = 0; acc = 8'h00;
   endtask

   // Applies the receive rules to one decoded bit exactly as given (no stuffing added).
   task automatic send_bit_unstuffed(input logic d);
      if (!in_pkt || dropped) begin
         send_dec(d, 1'b0, 1'b0, 8'h00, 1'b0);
      end else if (run == 6) begin
         if (d) begin
            dropped = 1;
            send_dec(d, 1'b0, 1'b0, 8'h00, 1'b1);
         end else begin
            run = 0;
            send_dec(d, 1'b0, 1'b0, 8'h00, 1'b0);
         end
      end else begin
         acc[nbits % 8] = d;
         nbits++;
         run = d ? run + 1 : 0;
         send_dec(d, 1'b0, (nbits % 8) == 0, acc, 1'b0);
      end
   endtask

   task automatic send_data_bit(input logic d);
      if (in_pkt && !dropped && run == 6) begin
         send_bit_unstuffed(1'b0);
         maybe_gap();
      end
      send_bit_unstuffed(d);
      maybe_gap();
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) send_data_bit(b[i]);
   endtask

   task automatic send_eop(input int n);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 8'h00,
           in_pkt, in_pkt && !dropped && (nbits % 8) != 0, 1'b0);
      for (int i = 1; i < n; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
              1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      level = 1'b1; in_pkt = 0; dropped = 0;
      idle($urandom_range(1, 3));
   endtask

   // Asserted just after an edge: outputs must drop before the next compare.
   task automatic reset_pulse();
      rst_L = 1'b0;
      last_byte = 8'h00;
      if (edge_n < MAXE) exp_q[edge_n] = '0;
      level = 1'b1; in_pkt = 0; dropped = 0; run = 0; nbits = 0;
      idle(2);
      rst_L = 1'b1;
   endtask

   task automatic snap();
      s_ps = mon_ps; s_bv = mon_bv; s_pe = mon_pe; s_se = mon_se; s_ae = mon_ae; s_peae = mon_peae;
   endtask

   initial begin
      for (int i = 0; i < MAXE; i++) exp_q[i] = '0;
      mon_ps = 0; mon_bv = 0; mon_pe = 0; mon_se = 0; mon_ae = 0; mon_peae = 0;
      mon_byte = 8'h00;
      level = 1'b1; run = 0; nbits = 0; in_pkt = 0; dropped = 0; gaps_on = 0;
      acc = 8'h00; last_byte = 8'h00; raw_log = 8'h00;
      bus.in_bit = 1'b0; bus.in_valid = 1'b0; bus.in_eop = 1'b0;

      idle(3);
      rst_L = 1'b1;
      check("reset byte_out", 32'(bus.byte_out), 32'h00);
      check("reset pulses", 32'({bus.byte_valid, bus.pkt_start, bus.pkt_end,
                                 bus.stuff_err, bus.align_err}), 32'h0);

      // Sync + 8'hA5 + EOP x3, preceded by an EOP seen while hunting
      snap();
      send_eop(2);
      send_sync();
      check("sync raw line pattern", 32'(raw_log), 32'h2A);
      send_byte(8'hA5);
      send_eop(3);
      idle(2);
      check("A5 pkt_start count", 32'(mon_ps - s_ps), 32'd1);
      check("A5 byte_valid count", 32'(mon_bv - s_bv), 32'd1);
      check("A5 byte value", 32'(mon_byte), 32'hA5);
      check("A5 pkt_end count", 32'(mon_pe - s_pe), 32'd1);
      check("A5 error count", 32'((mon_se - s_se) + (mon_ae - s_ae)), 32'd0);

      // 8'hFF needs a stuffed 0 after the sixth 1 (sync's final 1 included)
      snap();
      send_sync();
      send_byte(8'hFF);
      send_eop(2);
      idle(2);
      check("FF byte value", 32'(mon_byte), 32'hFF);
      check("FF stuff_err count", 32'(mon_se - s_se), 32'd0);

      // Seven unstuffed 1s: stuffing violation, packet dropped, then hunting resumes
      snap();
      send_sync();
      for (int i = 0; i < 7; i++) send_bit_unstuffed(1'b1);
      send_eop(2);
      idle(2);
      check("stuff err count", 32'(mon_se - s_se), 32'd1);
      check("stuff no byte", 32'(mon_bv - s_bv), 32'd0);
      check("stuff pkt_end", 32'(mon_pe - s_pe), 32'd1);
      check("stuff no align", 32'(mon_ae - s_ae), 32'd0);
      snap();
      send_sync();
      send_byte(8'h00);
      send_eop(1);
      idle(2);
      check("after drop pkt_start", 32'(mon_ps - s_ps), 32'd1);
      check("after drop byte", 32'(mon_byte), 32'h00);

      // 12 data bits: one byte then a 4-bit remainder at EOP
      snap();
      send_sync();
      begin
         logic [11:0] bits12;
         bits12 = 12'hABC;
         for (int i = 0; i < 12; i++) send_data_bit(bits12[i]);
      end
      send_eop(2);
      idle(2);
      check("partial byte_valid", 32'(mon_bv - s_bv), 32'd1);
      check("partial byte", 32'(mon_byte), 32'hBC);
      check("partial pe+ae same cycle", 32'(mon_peae - s_peae), 32'd1);

      // Valid gaps inside bytes, then reset in the middle of a byte
      gaps_on = 1;
      send_sync();
      send_byte(8'h3C);
      send_eop(2);
      idle(2);
      check("gapped byte", 32'(mon_byte), 32'h3C);
      snap();
      send_sync();
      for (int i = 0; i < 4; i++) send_data_bit(1'($urandom_range(0, 1)));
      reset_pulse();
      check("midreset byte_out", 32'(bus.byte_out), 32'h00);
      idle(2);
      check("midreset no pkt_end", 32'(mon_pe - s_pe), 32'd0);
      send_sync();
      send_byte(8'h5A);
      send_eop(2);
      idle(2);
      check("post-reset byte", 32'(mon_byte), 32'h5A);

      // Randomized packets
      for (int p = 0; p < 60; p++) begin
         int kind;
         gaps_on = 1'($urandom_range(0, 1));
         kind = $urandom_range(0, 5);
         if ($urandom_range(0, 4) == 0) send_eop($urandom_range(1, 2));
         send_sync();
         for (int k = $urandom_range(0, 3); k > 0; k--)
            send_byte(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
         if (kind == 0) begin
            for (int k = $urandom_range(1, 7); k > 0; k--) send_data_bit(1'($urandom_range(0, 1)));
         end else if (kind == 1) begin
            for (int k = 0; k < 7; k++) send_bit_unstuffed(1'b1);
            for (int k = $urandom_range(0, 5); k > 0; k--) send_data_bit(1'($urandom_range(0, 1)));
         end
         if (kind == 2) begin
            for (int k = $urandom_range(0, 6); k > 0; k--) send_data_bit(1'($urandom_range(0, 1)));
            reset_pulse();
            idle($urandom_range(1, 3));
         end else begin
            send_eop($urandom_range(1, 3));
         end
      end
      idle(3);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/usb_rx_decode.md
USB_RX_DECODE -- requirements
Module: usb_rx_decode

Interface
REQ-001 SHALL have `clk`, input, 1 bit: bit-rate clock.
REQ-002 SHALL have `rst_L`, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have `in_bit`, input, 1 bit: raw line level from the line decoder (1=J, 0=K).
REQ-004 SHALL have `in_valid`, input, 1 bit: `in_bit` is meaningful this cycle.
REQ-005 SHALL have `in_eop`, input, 1 bit: line decoder reports SE0/EOP phase; takes priority over `in_valid`.
REQ-006 SHALL have `byte_out`, output, 8 bits: assembled data byte, LSB received first.
REQ-007 SHALL have `byte_valid`, output, 1 bit: one-cycle pulse, `byte_out` valid.
REQ-008 SHALL have `pkt_start`, output, 1 bit: one-cycle pulse on sync detect.
REQ-009 SHALL have `pkt_end`, output, 1 bit: one-cycle pulse on the first EOP cycle of an active packet.
REQ-010 SHALL have `stuff_err`, output, 1 bit: one-cycle pulse on a bit-stuff violation.
REQ-011 SHALL have `align_err`, output, 1 bit: one-cycle pulse when EOP arrives with a partial byte.

Function
REQ-012 SHALL NRZI-decode each valid bit: decoded = 1 if `in_bit` equals the previous level, else 0; the previous level updates only on valid bits.
REQ-013 SHALL set the previous level to 1 (J) on reset and on every `in_eop` cycle.
REQ-014 SHALL implement states HUNT, DATA, DROP, EOP_WAIT; reset state HUNT.
REQ-015 HUNT SHALL shift decoded bits into an 8-bit register, newest at MSB; register == 8'h80 (decoded 0000000 then 1) -> DATA, pulse `pkt_start` next cycle.
REQ-016 HUNT SHALL clear the sync shift register on `in_eop`; no outputs pulse in HUNT on EOP.
REQ-017 On entering DATA, the ones counter SHALL be 1 (sync's final 1 counts), bit counter 0.
REQ-018 In DATA, each decoded 1 SHALL increment the ones counter; a decoded 0 clears it.
REQ-019 When the ones counter is 6, the next valid bit SHALL be a stuff bit: decoded 0 is discarded (ones=0, no bit count); decoded 1 -> pulse `stuff_err`, go DROP.
REQ-020 Non-stuff data bits SHALL shift into the byte register at bit 7 (shift right); bit counter is 3 bits and wraps 7->0.
REQ-021 On the 8th data bit, SHALL register `byte_out` and pulse `byte_valid` the following cycle (latency 1 clk from last bit sample).
REQ-022 `byte_out` SHALL hold its last value between pulses.
REQ-023 `in_eop` in DATA SHALL pulse `pkt_end`; if the bit counter != 0, SHALL also pulse `align_err` the same cycle and discard the partial byte; go to EOP_WAIT.
REQ-024 DROP SHALL ignore all bits; `in_eop` -> pulse `pkt_end`, go EOP_WAIT (no `align_err`).
REQ-025 EOP_WAIT SHALL remain until `in_eop`=0, then go to HUNT with counters cleared.
REQ-026 `in_valid`=0 with `in_eop`=0 SHALL hold all state and counters (idle stall).
REQ-027 All outputs SHALL be registered; at most one of `byte_valid`/`pkt_end` per cycle by construction.

Reset
REQ-028 `rst_L` low SHALL asynchronously force state HUNT, all counters 0, previous level 1, `byte_out`=8'h00, all pulse outputs 0.
REQ-029 Reset mid-packet SHALL drop the packet silently (no `pkt_end`/`align_err`).

Structure
REQ-030 `usb_pkg` SHALL hold the rx state enum, SYNC_DECODED=8'h80, STUFF_LIMIT=6, J/K level constants.
REQ-031 NRZI decoding SHALL be a sub-module `usb_nrzi_dec` (`clk`, `rst_L`, `in_bit`, `in_valid`, `in_eop` -> `dec_bit`, `dec_valid`).

Verification
REQ-032 Raw 0,1,0,1,0,1,0,0 (sync) then NRZI of 8'hA5 then EOP x3 -> `pkt_start` once, `byte_valid` with 8'hA5, `pkt_end` once, no errors.
REQ-033 Sync + byte 8'hFF (stuffed 0 after six 1s, counting sync's 1) -> `byte_out`=8'hFF, no `stuff_err`.
REQ-034 Sync + seven consecutive decoded 1s -> `stuff_err` pulse, no `byte_valid`; EOP -> `pkt_end`, then HUNT.
REQ-035 Sync + 12 data bits + EOP -> one `byte_valid`, `pkt_end` and `align_err` same cycle.
REQ-036 `in_valid` gaps of 3 cycles inside a byte -> same byte as the gap-free run; `rst_L` low mid-byte -> outputs 0, next sync decodes normally.
